seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_seg_decoder.sv | 33 +++
 rtl/seven_seg_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller and its decoder.
package seven_seg_pkg;

  // Per-digit scan phase: dark guard interval, then the anode is driven.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Active-low segments: all ones is fully dark, including the decimal point.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_ON_CYCLES   = 50000;
  localparam int DEF_DEAD_CYCLES = 500;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern; bit 7 (dp) is left dark.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  // Combinational lookup of the common-anode glyph for each hex value.
  always_comb begin
    // NOTE: assign a default before the case so no path can leave seg_o unassigned and infer a latch.
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit blank/on timing,
// registered active-low anode and segment drive, and a frame-synchronous
// display update through a one-deep pending register.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic [7:0]              seg_out,
  output logic                    frame_tick
);

  localparam int MAX_SLOT = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int CNT_W    = $clog2(MAX_SLOT + 1);
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_q;
  logic                    pend_full_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic                    accept;
  logic                    commit;

  logic [3:0]              nibble;
  logic [7:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    tick_q;

  // Next-state logic for the blank/on sequencer and the digit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Select the displayed nibble for the digit currently being scanned.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nibble = disp_q[4*i +: 4];
    end
  end

  seven_seg_decoder u_decoder (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // Drive pattern for the next cycle: lit only while ON and not masked dark.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (en && (state_q == ST_ON) && !blank_mask[idx_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dec_seg;
      if (dp_mask[idx_q]) seg_d[7] = 1'b0;
    end
  end

  // Registered display outputs and the end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      tick_q <= wrap;
    end
  end

  // A pending value moves to the display only on the frame_tick cycle or
  // when scanning is stopped, so a frame never shows a mix of two values.
  assign accept = load_valid && !pend_full_q;
  assign commit = pend_full_q && (tick_q || !en);

  // Pending and display registers for the load handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      if (commit) begin
        disp_q      <= pend_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_q      <= value_in;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign load_ready = !pend_full_q;
  assign digit_an   = an_q;
  assign seg_out    = seg_q;
  assign frame_tick = tick_q;

endmodule
